// File: rtl/car_control_pkg.sv
// Road-car lane constants and shared types.
// Lane tables are indexed 0..7 for lanes 1..8.
package car_control_pkg;

    localparam int NUM_LANES   = 8;
    localparam int H_DISPLAY   = 640;
    localparam int CAR_WIDTH   = 40;
    localparam int BASE_PERIOD = 250000;
    localparam int PERIOD_STEP = 7500;
    localparam int MIN_PERIOD  = 25000;

    typedef enum logic {
        DIR_LEFT  = 1'b0,
        DIR_RIGHT = 1'b1
    } dir_e;

    localparam int CAR_INIT_X [NUM_LANES] =
        '{0, 80, 160, 240, 320, 400, 480, 560};

    localparam int LANE_STEP [NUM_LANES] =
        '{1, 2, 2, 1, 3, 1, 2, 3};

    // Odd lanes drift left, even lanes drift right.
    localparam dir_e LANE_DIR [NUM_LANES] =
        '{DIR_LEFT, DIR_RIGHT, DIR_LEFT, DIR_RIGHT,
          DIR_LEFT, DIR_RIGHT, DIR_LEFT, DIR_RIGHT};

    localparam int CAR_Y [NUM_LANES] =
        '{60, 110, 160, 210, 260, 310, 360, 410};

endpackage

// File: rtl/car_control_if.sv
// Bundle between the car generator and its consumers.
// master = player/renderer side, slave = car_control.
interface car_control_if;

    logic [4:0] speed_car;
    logic       RUN;
    logic       RESTART;
    logic [9:0] car_x1;
    logic [9:0] car_x2;
    logic [9:0] car_x3;
    logic [9:0] car_x4;
    logic [9:0] car_x5;
    logic [9:0] car_x6;
    logic [9:0] car_x7;
    logic [9:0] car_x8;
    logic       TICK;

    modport master (
        output speed_car, RUN, RESTART,
        input  car_x1, car_x2, car_x3, car_x4,
        input  car_x5, car_x6, car_x7, car_x8,
        input  TICK
    );

    modport slave (
        input  speed_car, RUN, RESTART,
        output car_x1, car_x2, car_x3, car_x4,
        output car_x5, car_x6, car_x7, car_x8,
        output TICK
    );

endinterface

// File: rtl/car_control_lane.sv
// One road lane: x position stepping with wrap on tick.
// Restart reloads the start position and beats a tick.
module car_lane
    import car_control_pkg::*;
#(
    parameter int   INIT_X    = 0,
    parameter int   STEP      = 1,
    parameter dir_e DIR       = DIR_LEFT,
    parameter int   H_DISPLAY = 640
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       tick,
    input  logic       restart,
    output logic [9:0] x
);

    localparam logic [10:0] STEP_W = 11'(STEP);
    localparam logic [10:0] H_W    = 11'(H_DISPLAY);
    localparam logic [9:0]  INIT_W = 10'(INIT_X);

    logic [9:0]  x_q;
    logic [9:0]  x_d;
    logic [10:0] raw;
    logic [10:0] nxt;

    // 11-bit arithmetic keeps x + H_DISPLAY from overflowing.
    always_comb begin
        raw = {1'b0, x_q};
        if (DIR == DIR_RIGHT) begin
            raw = {1'b0, x_q} + STEP_W;
        end else if ({1'b0, x_q} < STEP_W) begin
            raw = {1'b0, x_q} + H_W - STEP_W;
        end else begin
            raw = {1'b0, x_q} - STEP_W;
        end
        nxt = raw;
        if (raw >= H_W) begin
            nxt = raw - H_W;
        end
    end

    always_comb begin
        x_d = x_q;
        if (restart) begin
            x_d = INIT_W;
        end else if (tick) begin
            x_d = 10'(nxt);
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            x_q <= INIT_W;
        end else begin
            x_q <= x_d;
        end
    end

    assign x = x_q;

endmodule

// File: rtl/car_control.sv
// Movement-tick generator and eight road lanes.
// Tick period shrinks with speed_car, floored at MIN_PERIOD.
module car_control
    import car_control_pkg::*;
#(
    parameter int H_DISPLAY   = car_control_pkg::H_DISPLAY,
    parameter int BASE_PERIOD = car_control_pkg::BASE_PERIOD,
    parameter int PERIOD_STEP = car_control_pkg::PERIOD_STEP,
    parameter int MIN_PERIOD  = car_control_pkg::MIN_PERIOD
) (
    input logic         CLK,
    input logic         RST_N,
    car_control_if.slave bus
);

    localparam logic [31:0] BASE_W = 32'(BASE_PERIOD);
    localparam logic [31:0] STEP_W = 32'(PERIOD_STEP);
    localparam logic [31:0] MIN_W  = 32'(MIN_PERIOD);
    localparam logic [31:0] SPAN_W = BASE_W - MIN_W;

    logic [31:0] cnt_q;
    logic [31:0] cnt_d;
    logic [31:0] period_q;
    logic [31:0] period_d;
    logic [31:0] prod;
    logic [31:0] p_raw;
    logic        tick;
    logic [9:0]  lane_x [NUM_LANES];

    always_comb begin
        prod  = 32'(bus.speed_car) * STEP_W;
        p_raw = BASE_W - prod;
        if (prod > SPAN_W) begin
            p_raw = MIN_W;
        end
    end

    // Restart and a frozen RUN both mask a due tick.
    assign tick = bus.RUN && !bus.RESTART &&
                  (cnt_q == period_q - 32'd1);

    always_comb begin
        cnt_d    = cnt_q;
        period_d = period_q;
        if (bus.RESTART) begin
            cnt_d    = '0;
            period_d = p_raw;
        end else if (bus.RUN) begin
            if (tick) begin
                cnt_d    = '0;
                period_d = p_raw;
            end else begin
                cnt_d = cnt_q + 32'd1;
            end
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            cnt_q    <= '0;
            period_q <= BASE_W;
        end else begin
            cnt_q    <= cnt_d;
            period_q <= period_d;
        end
    end

    for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
        car_lane #(
            .INIT_X    (CAR_INIT_X[g]),
            .STEP      (LANE_STEP[g]),
            .DIR       (LANE_DIR[g]),
            .H_DISPLAY (H_DISPLAY)
        ) u_lane (
            .CLK     (CLK),
            .RST_N   (RST_N),
            .tick    (tick),
            .restart (bus.RESTART),
            .x       (lane_x[g])
        );
    end

    assign bus.TICK   = tick;
    assign bus.car_x1 = lane_x[0];
    assign bus.car_x2 = lane_x[1];
    assign bus.car_x3 = lane_x[2];
    assign bus.car_x4 = lane_x[3];
    assign bus.car_x5 = lane_x[4];
    assign bus.car_x6 = lane_x[5];
    assign bus.car_x7 = lane_x[6];
    assign bus.car_x8 = lane_x[7];

endmodule

// File: tb/tb_car_control.sv
// Directed scoreboard bench for car_control with short
// sim periods (base 20, step 4, floor 5).
module tb_car_control;

    localparam int INIT_X [8] =
        '{0, 80, 160, 240, 320, 400, 480, 560};
    localparam int STEPS [8] = '{1, 2, 2, 1, 3, 1, 2, 3};

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    car_control_if bus ();

    car_control #(
        .H_DISPLAY   (640),
        .BASE_PERIOD (20),
        .PERIOD_STEP (4),
        .MIN_PERIOD  (5)
    ) dut (
        .CLK   (clk),
        .RST_N (rst_n),
        .bus   (bus)
    );

    logic [9:0] dx [8];
    assign dx[0] = bus.car_x1;
    assign dx[1] = bus.car_x2;
    assign dx[2] = bus.car_x3;
    assign dx[3] = bus.car_x4;
    assign dx[4] = bus.car_x5;
    assign dx[5] = bus.car_x6;
    assign dx[6] = bus.car_x7;
    assign dx[7] = bus.car_x8;

    exp_t sb [$];
    int checks   = 0;
    int failures = 0;
    int mx [8];

    function automatic void push(string tag, logic [31:0] v);
        exp_t e;
        e.tag = tag;
        e.val = v;
        sb.push_back(e);
    endfunction

    task automatic chk(input logic [31:0] obs);
        exp_t e;
        checks++;
        if (sb.size() == 0) begin
            failures++;
            $error("FAIL sb_empty observed=%0d", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.val) else begin
                failures++;
                $error("FAIL %s observed=%0d expected=%0d",
                       e.tag, obs, e.val);
            end
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_tick(output int n);
        n = 0;
        while (bus.TICK !== 1'b1 && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < 8; i++) mx[i] = INIT_X[i];
    endfunction

    function automatic void model_step();
        for (int i = 0; i < 8; i++) begin
            if (i % 2 == 0) mx[i] = (mx[i] + 640 - STEPS[i]) % 640;
            else            mx[i] = (mx[i] + STEPS[i]) % 640;
        end
    endfunction

    task automatic check_pos(input string tag);
        for (int i = 0; i < 8; i++)
            push($sformatf("%s_x%0d", tag, i + 1), mx[i]);
        for (int i = 0; i < 8; i++)
            chk(32'(dx[i]));
    endtask

    task automatic tick_and_step(input int exp_n, input string tag);
        int n;
        push(tag, exp_n);
        wait_tick(n);
        chk(n);
        model_step();
        cyc(1);
        check_pos(tag);
    endtask

    initial begin
        int ticks;
        int pre2;
        int pre8;
        bus.speed_car = 5'd0;
        bus.RUN       = 1'b0;
        bus.RESTART   = 1'b0;
        model_reset();
        #12;
        check_pos("rst");
        push("rst_tick", 0);
        chk(32'(bus.TICK));

        @(posedge clk);
        #1;
        rst_n   = 1'b1;
        bus.RUN = 1'b1;
        tick_and_step(19, "first_tick");
        push("x1_lwrap", 639);
        chk(32'(dx[0]));
        push("x2_step", 82);
        chk(32'(dx[1]));
        push("x5_step", 317);
        chk(32'(dx[4]));

        cyc(5);
        bus.speed_car = 5'd3;
        tick_and_step(14, "per20_hold");
        tick_and_step(7, "per8");
        bus.speed_car = 5'd31;
        tick_and_step(7, "per8_again");
        tick_and_step(4, "per5");

        for (int k = 0; k < 286; k++) begin
            pre2 = mx[1];
            pre8 = mx[7];
            tick_and_step(4, "per5_run");
            if (pre8 == 638) begin
                push("wrap_x8", 1);
                chk(32'(dx[7]));
            end
            if (pre2 == 638) begin
                push("wrap_x2", 0);
                chk(32'(dx[1]));
            end
        end

        cyc(4);
        push("tick_due", 1);
        chk(32'(bus.TICK));
        bus.RESTART   = 1'b1;
        bus.speed_car = 5'd0;
        #1;
        push("tick_restart", 0);
        chk(32'(bus.TICK));
        @(posedge clk);
        #1;
        bus.RESTART = 1'b0;
        model_reset();
        check_pos("restart");
        tick_and_step(19, "after_restart");

        cyc(7);
        bus.RUN = 1'b0;
        ticks = 0;
        repeat (50) begin
            @(posedge clk);
            #1;
            if (bus.TICK !== 1'b0) ticks++;
        end
        push("frozen_ticks", 0);
        chk(ticks);
        check_pos("frozen");
        bus.RUN = 1'b1;
        tick_and_step(12, "resume");

        cyc(19);
        push("tick_pre_rst", 1);
        chk(32'(bus.TICK));
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_pos("async_rst");
        push("async_rst_tick", 0);
        chk(32'(bus.TICK));
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick_and_step(19, "after_reset");

        $display("TB_RESULT checks=%0d failures=%0d",
                 checks, failures);
        $finish;
    end

endmodule
